// File: rtl/flash_phy_op_sched_if.sv
// rtl/flash_phy_op_sched_if.sv - request/completion bundle between requester and op scheduler
//
// Purpose: carries one flash operation request and its completion pulses.
// Signals:
//   req_i, rd_i, prog_i, pg_erase_i, bk_erase_i  request level and operation type
//   he_en_i                                      high-endurance erase (doubles erase latency)
//   erase_suspend_i                              level request to suspend an in-flight erase
//   rd_done_o, prog_done_o, erase_done_o         one-cycle completion pulses
//   error_o                                      one-cycle malformed-request pulse
//   suspended_o                                  marks an erase_done_o caused by suspend
//   busy_o                                       scheduler not idle
// Modports: master = requester side, slave = scheduler side.

interface flash_phy_op_sched_if;
   logic req_i;
   logic rd_i;
   logic prog_i;
   logic pg_erase_i;
   logic bk_erase_i;
   logic he_en_i;
   logic erase_suspend_i;
   logic rd_done_o;
   logic prog_done_o;
   logic erase_done_o;
   logic error_o;
   logic suspended_o;
   logic busy_o;

   modport master (
      output req_i, rd_i, prog_i, pg_erase_i, bk_erase_i, he_en_i, erase_suspend_i,
      input  rd_done_o, prog_done_o, erase_done_o, error_o, suspended_o, busy_o
   );

   modport slave (
      input  req_i, rd_i, prog_i, pg_erase_i, bk_erase_i, he_en_i, erase_suspend_i,
      output rd_done_o, prog_done_o, erase_done_o, error_o, suspended_o, busy_o
   );
endinterface

// File: rtl/flash_phy_op_sched.sv
// rtl/flash_phy_op_sched.sv - flash operation timer with erase suspend and malformed-request flagging
//
// Purpose: accepts one operation at a time, holds it for its fixed latency, then pulses
// the matching done. An erase may be suspended; malformed requests pulse error_o with all dones.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     flash_phy_op_sched_if.slave (request inputs, registered pulse/busy outputs)

module flash_phy_op_sched #(
   parameter int RdCycles      = 2,
   parameter int ProgCycles    = 8,
   parameter int PgEraseCycles = 32,
   parameter int BkEraseCycles = 128,
   parameter int SuspendCycles = 3,
   parameter int CntW          = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   flash_phy_op_sched_if.slave   bus
);

   localparam int CntMax = (1 << CntW) - 1;
   localparam bit ParamsOk = (RdCycles >= 1) && (RdCycles <= CntMax) &&
                             (ProgCycles >= 1) && (ProgCycles <= CntMax) &&
                             (PgEraseCycles >= 1) && (2 * PgEraseCycles <= CntMax) &&
                             (BkEraseCycles >= 1) && (2 * BkEraseCycles <= CntMax) &&
                             (SuspendCycles >= 1) && (SuspendCycles <= CntMax);

   if (!ParamsOk) begin : g_param_check
      $error("flash_phy_op_sched: latency parameter out of range for CntW");
   end

   localparam logic [CntW-1:0] LatRd     = CntW'(RdCycles);
   localparam logic [CntW-1:0] LatProg   = CntW'(ProgCycles);
   localparam logic [CntW-1:0] LatPg     = CntW'(PgEraseCycles);
   localparam logic [CntW-1:0] LatPgHe   = CntW'(2 * PgEraseCycles);
   localparam logic [CntW-1:0] LatBk     = CntW'(BkEraseCycles);
   localparam logic [CntW-1:0] LatBkHe   = CntW'(2 * BkEraseCycles);
   localparam logic [CntW-1:0] LatSusp   = CntW'(SuspendCycles);
   localparam logic [CntW-1:0] CntOne    = CntW'(1);

   typedef enum logic [1:0] {StIdle, StBusy, StSuspend, StWaitLow} state_e;
   typedef enum logic [1:0] {OpRd, OpProg, OpPgErase, OpBkErase} op_e;

   state_e          state_q, state_d;
   op_e             op_q, op_d, op_sel;
   logic [CntW-1:0] cnt_q, cnt_d, lat_sel;
   logic            rd_done_q, prog_done_q, erase_done_q, error_q, suspended_q, busy_q;
   logic            rd_done_d, prog_done_d, erase_done_d, error_d, suspended_d, busy_d;
   logic            fin;
   op_e             fin_op;
   logic            op_onehot;

   assign op_onehot = $onehot({bus.rd_i, bus.prog_i, bus.pg_erase_i, bus.bk_erase_i});

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      op_sel      = OpRd;
      lat_sel     = LatRd;
      fin         = 1'b0;
      fin_op      = op_q;
      error_d     = 1'b0;
      suspended_d = 1'b0;

      if (bus.prog_i) begin
         op_sel  = OpProg;
         lat_sel = LatProg;
      end else if (bus.pg_erase_i) begin
         op_sel  = OpPgErase;
         lat_sel = bus.he_en_i ? LatPgHe : LatPg;
      end else if (bus.bk_erase_i) begin
         op_sel  = OpBkErase;
         lat_sel = bus.he_en_i ? LatBkHe : LatBk;
      end

      case (state_q)
         StIdle: begin
            if (bus.req_i) begin
               if (op_onehot) begin
                  op_d = op_sel;
                  // Outputs are registered, so the done for a latency of L is
                  // launched L-1 edges after accept; L=1 completes on accept.
                  if (lat_sel == CntOne) begin
                     fin     = 1'b1;
                     fin_op  = op_sel;
                     state_d = StWaitLow;
                  end else begin
                     cnt_d   = lat_sel - CntOne;
                     state_d = StBusy;
                  end
               end else begin
                  error_d = 1'b1;
                  state_d = StWaitLow;
               end
            end
         end
         StBusy: begin
            // cnt_q==1 is the completion cycle; suspend is ignored there.
            if (cnt_q == CntOne) begin
               fin     = 1'b1;
               cnt_d   = '0;
               state_d = StWaitLow;
            end else if (bus.erase_suspend_i && (op_q == OpPgErase || op_q == OpBkErase)) begin
               if (LatSusp == CntOne) begin
                  fin         = 1'b1;
                  suspended_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = StWaitLow;
               end else begin
                  cnt_d   = LatSusp - CntOne;
                  state_d = StSuspend;
               end
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
         StSuspend: begin
            if (cnt_q == CntOne) begin
               fin         = 1'b1;
               suspended_d = 1'b1;
               cnt_d       = '0;
               state_d     = StWaitLow;
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
         StWaitLow: begin
            if (!bus.req_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // A malformed request reports every done alongside error.
      rd_done_d    = error_d || (fin && fin_op == OpRd);
      prog_done_d  = error_d || (fin && fin_op == OpProg);
      erase_done_d = error_d || (fin && (fin_op == OpPgErase || fin_op == OpBkErase));
      busy_d       = (state_d != StIdle);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         op_q         <= OpRd;
         rd_done_q    <= 1'b0;
         prog_done_q  <= 1'b0;
         erase_done_q <= 1'b0;
         error_q      <= 1'b0;
         suspended_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_q         <= op_d;
         rd_done_q    <= rd_done_d;
         prog_done_q  <= prog_done_d;
         erase_done_q <= erase_done_d;
         error_q      <= error_d;
         suspended_q  <= suspended_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.rd_done_o    = rd_done_q;
   assign bus.prog_done_o  = prog_done_q;
   assign bus.erase_done_o = erase_done_q;
   assign bus.error_o      = error_q;
   assign bus.suspended_o  = suspended_q;
   assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_flash_phy_op_sched.sv
// tb/tb_flash_phy_op_sched.sv - self-checking bench for flash_phy_op_sched

module tb_flash_phy_op_sched;

   localparam int RD   = 2;
   localparam int PROG = 8;
   localparam int PG   = 32;
   localparam int BK   = 128;
   localparam int SUSP = 3;

   // Operation kinds used by the bench: 0 read, 1 program, 2 page erase,
   // 3 bank erase, 4 rd+prog, 5 no op bit, 6 random malformed pattern.
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   flash_phy_op_sched_if bus ();

   flash_phy_op_sched #(
      .RdCycles(RD), .ProgCycles(PROG), .PgEraseCycles(PG),
      .BkEraseCycles(BK), .SuspendCycles(SUSP), .CntW(16)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic int op_lat(int kind, bit he);
      case (kind)
         0: return RD;
         1: return PROG;
         2: return he ? 2 * PG : PG;
         3: return he ? 2 * BK : BK;
         default: return 1;
      endcase
   endfunction

   function automatic bit suspend_takes(int kind, bit he, int s);
      return (kind == 2 || kind == 3) && s >= 1 && s <= op_lat(kind, he) - 2;
   endfunction

   function automatic int done_cycle(int kind, bit he, int s);
      return suspend_takes(kind, he, s) ? s + SUSP : op_lat(kind, he);
   endfunction

   // Expected {busy, suspended, error, erase_done, prog_done, rd_done} in cycle k.
   function automatic logic [5:0] expect_at(int k, int kind, bit he, int s, int extra);
      logic [5:0] v;
      int d;
      int rel;
      v   = '0;
      d   = done_cycle(kind, he, s);
      rel = d + extra + 1;
      v[5] = (k >= 1 && k <= rel);
      if (k == d) begin
         case (kind)
            0: v[0] = 1'b1;
            1: v[1] = 1'b1;
            2, 3: begin
               v[2] = 1'b1;
               v[4] = suspend_takes(kind, he, s);
            end
            default: v[3:0] = 4'b1111;
         endcase
      end
      return v;
   endfunction

   function automatic logic [5:0] observe();
      return {bus.busy_o, bus.suspended_o, bus.error_o, bus.erase_done_o,
              bus.prog_done_o, bus.rd_done_o};
   endfunction

   task automatic clear_inputs();
      bus.req_i = 1'b0; bus.rd_i = 1'b0; bus.prog_i = 1'b0;
      bus.pg_erase_i = 1'b0; bus.bk_erase_i = 1'b0;
      bus.he_en_i = 1'b0; bus.erase_suspend_i = 1'b0;
   endtask

   task automatic set_op(int kind);
      logic [3:0] b;
      case (kind)
         0: b = 4'b0001;
         1: b = 4'b0010;
         2: b = 4'b0100;
         3: b = 4'b1000;
         4: b = 4'b0011;
         5: b = 4'b0000;
         default: begin
            b = 4'($urandom_range(0, 15));
            while ($countones(b) == 1) b = 4'($urandom_range(0, 15));
         end
      endcase
      {bus.bk_erase_i, bus.pg_erase_i, bus.prog_i, bus.rd_i} = b;
   endtask

   // Drives one request from acceptance through return to idle, comparing every cycle.
   task automatic run_case(string name, int kind, bit he, int s, int extra, bit scramble);
      int d;
      int rel;
      logic [5:0] obs;
      logic [5:0] exp;
      d   = done_cycle(kind, he, s);
      rel = d + extra + 1;
      for (int k = 0; k <= rel + 1; k++) begin
         @(posedge clk);
         #1;
         bus.req_i = (k <= d + extra);
         if (k == 0) begin
            set_op(kind);
            bus.he_en_i = he;
         end else if (scramble) begin
            {bus.bk_erase_i, bus.pg_erase_i, bus.prog_i, bus.rd_i} = 4'($urandom_range(0, 15));
            bus.he_en_i = 1'($urandom_range(0, 1));
         end
         bus.erase_suspend_i = (s >= 0 && k >= s && k <= d + extra);
         @(negedge clk);
         obs = observe();
         exp = expect_at(k, kind, he, s, extra);
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got {busy,susp,err,erase,prog,rd}=%b expected %b",
                     name, k, obs, exp);
         end
      end
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (observe() !== 6'b0) begin
         failures++;
         $display("FAIL reset_state: got %b expected 000000", observe());
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (observe() !== 6'b0) begin
            failures++;
            $display("FAIL reset_idle: got %b expected 000000", observe());
         end
      end
   endtask

   task automatic test_read();
      run_case("read", 0, 1'b0, -1, 0, 1'b0);
   endtask

   task automatic test_erase_latency();
      run_case("pg_erase_he", 2, 1'b1, -1, 0, 1'b0);
      run_case("bk_erase", 3, 1'b0, -1, 1, 1'b0);
   endtask

   task automatic test_suspend();
      run_case("suspend_c10", 2, 1'b0, 10, 0, 1'b0);
      run_case("suspend_at_done", 2, 1'b0, 32, 1, 1'b0);
      run_case("suspend_during_read", 0, 1'b0, 1, 0, 1'b0);
      run_case("suspend_during_prog", 1, 1'b0, 2, 0, 1'b0);
   endtask

   task automatic test_malformed();
      run_case("malformed_rd_prog", 4, 1'b0, -1, 0, 1'b0);
      run_case("malformed_none", 5, 1'b0, -1, 2, 1'b0);
   endtask

   task automatic test_handshake();
      run_case("prog_hold5", 1, 1'b0, -1, 5, 1'b0);
      run_case("read_after_prog", 0, 1'b0, -1, 0, 1'b0);
   endtask

   task automatic test_reset_mid_op();
      logic [5:0] exp;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         bus.req_i = 1'b1;
         if (k == 0) set_op(3);
         @(negedge clk);
         exp = expect_at(k, 3, 1'b0, -1, 0);
         checks++;
         if (observe() !== exp) begin
            failures++;
            $display("FAIL bk_before_reset cycle %0d: got %b expected %b", k, observe(), exp);
         end
      end
      @(posedge clk);
      #1 rst_n = 1'b0;
      clear_inputs();
      #1;
      checks++;
      if (observe() !== 6'b0) begin
         failures++;
         $display("FAIL async_reset_outputs: got %b expected 000000", observe());
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < BK + 10; k++) begin
         @(negedge clk);
         checks++;
         if (observe() !== 6'b0) begin
            failures++;
            $display("FAIL no_done_after_reset cycle %0d: got %b expected 000000", k, observe());
         end
      end
      run_case("read_after_reset", 0, 1'b0, -1, 0, 1'b0);
   endtask

   task automatic test_random();
      int kind;
      bit he;
      int s;
      int l;
      for (int i = 0; i < 25; i++) begin
         kind = $urandom_range(0, 6);
         he   = 1'($urandom_range(0, 1));
         l    = op_lat(kind, he);
         s    = -1;
         if ($urandom_range(0, 1) == 1) begin
            if (kind == 2 || kind == 3) s = $urandom_range(1, l - 2);
            else s = $urandom_range(0, l + 2);
         end
         run_case($sformatf("random_%0d_kind%0d", i, kind), kind, he, s,
                  $urandom_range(0, 4), 1'b1);
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_read();
      test_erase_latency();
      test_suspend();
      test_malformed();
      test_handshake();
      test_reset_mid_op();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
